// File: rtl/mem_map_pkg.sv
// Memory map, access-size encodings and timer control bit positions shared by
// the MEM stage, its bus interface users and the testbench.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h4000_0000;

    localparam logic [7:0]  OFF_TH      = 8'h00;
    localparam logic [7:0]  OFF_TL      = 8'h04;
    localparam logic [7:0]  OFF_TCON    = 8'h08;
    localparam logic [7:0]  OFF_LEDS    = 8'h0C;
    localparam logic [7:0]  OFF_DIGI    = 8'h10;
    localparam logic [7:0]  OFF_SYSTICK = 8'h14;

    localparam logic [1:0]  SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  SIZE_HALF   = 2'b01;
    localparam logic [1:0]  SIZE_WORD   = 2'b10;

    localparam int unsigned TCON_RUN    = 0;
    localparam int unsigned TCON_IE     = 1;
    localparam int unsigned TCON_IRQ    = 2;

    // Byte lanes touched by a store of the given size at the given low address bits.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_mmio_if.sv
// CPU-side data-memory bus between EX/MEM and the MEM stage.
//   master: drives address, store data, strobes, size, extension mode; receives load data.
//   slave : the MEM stage.
interface mem_stage_mmio_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_unsigned,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_unsigned,
        output mem_rdata
    );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern; bit 7 is the decimal point (held off).
//   nibble : 4-bit value to show
//   seg_c  : {dp, g, f, e, d, c, b, a}, active low, combinational
module seg7_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg_c
);
    always_comb begin
        seg_c = 8'hFF;
        case (nibble)
            4'h0: seg_c = 8'hC0;
            4'h1: seg_c = 8'hF9;
            4'h2: seg_c = 8'hA4;
            4'h3: seg_c = 8'hB0;
            4'h4: seg_c = 8'h99;
            4'h5: seg_c = 8'h92;
            4'h6: seg_c = 8'h82;
            4'h7: seg_c = 8'hF8;
            4'h8: seg_c = 8'h80;
            4'h9: seg_c = 8'h90;
            4'hA: seg_c = 8'h88;
            4'hB: seg_c = 8'h83;
            4'hC: seg_c = 8'hC6;
            4'hD: seg_c = 8'hA1;
            4'hE: seg_c = 8'h86;
            4'hF: seg_c = 8'h8E;
            default: seg_c = 8'hFF;
        endcase
    end
endmodule

// File: rtl/mem_stage_mmio.sv
// MEM pipeline stage: word-organised data RAM with byte/half/word access and
// sign/zero-extended loads, plus an MMIO window (timer with interrupt, LEDs,
// scanned 7-segment display, free-running systick) and a RAM debug view.
// Ports:
//   clk, reset      clock; asynchronous active-low reset (deassert synchronised here)
//   bus             CPU data bus (slave side); mem_rdata is combinational
//   interrupt       timer irq status (TCON[2])
//   leds            LED register
//   digi            {anodes one-hot active-low, segments active-low}, registered
//   check/showaddr  debug: display hex of RAM[showaddr]
//   ramshowdata     RAM[showaddr], combinational
//   misalign        only when MISALIGN_TRAP_EN is defined
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage_mmio
    import mem_map_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned SHOW_AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_stage_mmio_if.slave         bus,
    output logic                    interrupt,
    output logic [LED_W-1:0]        leds,
    output logic [NUM_DIGITS+7:0]   digi,
    input  logic                    check,
    input  logic [SHOW_AW-1:0]      showaddr,
    output logic [31:0]             ramshowdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                    misalign
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [1:0]       rst_ff;
    logic             rst_n;
    logic [31:0]      ram [DEPTH];
    logic [31:0]      th, tl, systick, digi_reg;
    logic [2:0]       tcon;
    logic [LED_W-1:0] led_reg;
    logic [DW-1:0]    div;
    logic [IW-1:0]    idx;

    logic             mis, ram_sel, mmio_sel, ram_we, mmio_we, ovf;
    logic [AW-1:0]    widx;
    logic [5:0]       reg_off;
    logic [31:0]      rword, byte_sh, half_sh, ram_ld, wdata_rep;
    logic [3:0]       be, nib;
    logic [7:0]       seg_hex, seg_raw, seg;

    // Async assert, two-flop synchronised deassert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_ff <= 2'b00;
        else        rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_n = rst_ff[1];

`ifdef MISALIGN_TRAP_EN
    assign mis = (bus.mem_read || bus.mem_write) &&
                 (((bus.mem_size == SIZE_HALF) && bus.mem_addr[0]) ||
                  (bus.mem_size[1] && (bus.mem_addr[1:0] != 2'b00)));
    assign misalign = mis;
`else
    assign mis = 1'b0;
`endif

    // Address decode: RAM below DEPTH*4; MMIO is word-access only.
    assign ram_sel  = (bus.mem_addr[31:AW+2] == '0);
    assign mmio_sel = (bus.mem_addr[31:8] == MMIO_BASE[31:8]) && bus.mem_size[1];
    assign widx     = bus.mem_addr[AW+1:2];
    assign reg_off  = bus.mem_addr[7:2];
    assign rword    = ram[widx];
    assign ovf      = tcon[TCON_RUN] && (tl == 32'hFFFF_FFFF);

    // Load lane select and extension.
    always_comb begin
        byte_sh = rword >> {bus.mem_addr[1:0], 3'b000};
        half_sh = rword >> {bus.mem_addr[1], 4'b0000};
        ram_ld  = rword;
        case (bus.mem_size)
            SIZE_BYTE: ram_ld = bus.mem_unsigned ? {24'b0, byte_sh[7:0]}
                                                 : {{24{byte_sh[7]}}, byte_sh[7:0]};
            SIZE_HALF: ram_ld = bus.mem_unsigned ? {16'b0, half_sh[15:0]}
                                                 : {{16{half_sh[15]}}, half_sh[15:0]};
            default:   ram_ld = rword;
        endcase
    end

    // Load data mux; zero when idle, trapped or unmapped.
    always_comb begin
        bus.mem_rdata = '0;
        if (bus.mem_read && !mis) begin
            if (ram_sel) begin
                bus.mem_rdata = ram_ld;
            end else if (mmio_sel) begin
                case (reg_off)
                    OFF_TH[7:2]:      bus.mem_rdata = th;
                    OFF_TL[7:2]:      bus.mem_rdata = tl;
                    OFF_TCON[7:2]:    bus.mem_rdata = {29'b0, tcon};
                    OFF_LEDS[7:2]:    bus.mem_rdata = 32'(led_reg);
                    OFF_DIGI[7:2]:    bus.mem_rdata = digi_reg;
                    OFF_SYSTICK[7:2]: bus.mem_rdata = systick;
                    default:          bus.mem_rdata = '0;
                endcase
            end
        end
    end

    // Store path: replicate data across lanes, enable only the addressed ones.
    always_comb begin
        case (bus.mem_size)
            SIZE_BYTE: wdata_rep = {4{bus.mem_wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{bus.mem_wdata[15:0]}};
            default:   wdata_rep = bus.mem_wdata;
        endcase
    end
    assign be      = byte_en(bus.mem_size, bus.mem_addr[1:0]);
    assign ram_we  = bus.mem_write && !mis && ram_sel && rst_n;
    assign mmio_we = bus.mem_write && !mis && mmio_sel;

    // RAM array, not reset; stores blocked while in reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign ramshowdata = ram[AW'(showaddr)];

    // Timer, LEDs, display register, systick. CPU write to TL/TH overrides the
    // timer update; the irq set is applied last so it beats a coincident TCON write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th       <= '0;
            tl       <= '0;
            tcon     <= '0;
            led_reg  <= '0;
            digi_reg <= '0;
            systick  <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (tcon[TCON_RUN]) tl <= ovf ? th : tl + 32'd1;
            if (mmio_we) begin
                case (reg_off)
                    OFF_TH[7:2]:   th       <= bus.mem_wdata;
                    OFF_TL[7:2]:   tl       <= bus.mem_wdata;
                    OFF_TCON[7:2]: tcon     <= bus.mem_wdata[2:0];
                    OFF_LEDS[7:2]: led_reg  <= bus.mem_wdata[LED_W-1:0];
                    OFF_DIGI[7:2]: digi_reg <= bus.mem_wdata;
                    default: ;
                endcase
            end
            if (ovf && tcon[TCON_IE]) tcon[TCON_IRQ] <= 1'b1;
        end
    end

    assign interrupt = tcon[TCON_IRQ];
    assign leds      = led_reg;

    // Segment source for the current digit: hex of debug word or raw DIGI byte.
    assign nib     = 4'(ramshowdata >> {idx, 2'b00});
    assign seg_raw = (32'(idx) < 32'd4) ? 8'(digi_reg >> {idx, 3'b000}) : 8'hFF;

    seg7_decode u_seg7_decode (
        .nibble (nib),
        .seg_c  (seg_hex)
    );

    assign seg = check ? seg_hex : seg_raw;

    // Digit scan: divider then digit index; digi is registered from the current index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            idx  <= '0;
            digi <= {~NUM_DIGITS'(1), 8'hFF};
        end else begin
            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                div <= div + DW'(1);
            end
            digi <= {~(NUM_DIGITS'(1) << idx), seg};
        end
    end

endmodule

// File: tb/tb_mem_stage_mmio.sv
module tb_mem_stage_mmio;
    import mem_map_pkg::*;

    localparam int unsigned ND = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          interrupt;
    logic [7:0]    leds;
    logic [ND+7:0] digi;
    logic          check;
    logic [7:0]    showaddr;
    logic [31:0]   ramshowdata;
`ifdef MISALIGN_TRAP_EN
    logic          misalign;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    mem_stage_mmio_if bus();

    mem_stage_mmio #(
        .DEPTH(256), .LED_W(8), .NUM_DIGITS(ND), .SCAN_DIV(4), .SHOW_AW(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .interrupt   (interrupt),
        .leds        (leds),
        .digi        (digi),
        .check       (check),
        .showaddr    (showaddr),
        .ramshowdata (ramshowdata)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: expectation queued at stimulus time, popped when the output is sampled.
    task automatic observe(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) chk({tag, "_noexp"}, 32'd0, 32'd1);
        else                   chk(tag, got, exp_q.pop_front());
    endtask

    task automatic pin(input string tag, input logic [31:0] got, input logic [31:0] exp);
        exp_q.push_back(exp);
        observe(tag, got);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_size  = sz;
        bus.mem_write = 1'b1;
        @(negedge clk);
        bus.mem_write = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] e);
        @(negedge clk);
        exp_q.push_back(e);
        bus.mem_addr     = a;
        bus.mem_size     = sz;
        bus.mem_unsigned = u;
        bus.mem_read     = 1'b1;
        #1;
        observe(tag, bus.mem_rdata);
        bus.mem_read = 1'b0;
    endtask

    // Align on digit 0 and check 16 display samples (4 per digit).
    task automatic scan_run(input string tag, input logic [31:0] segs);
        int n = 0;
        logic [3:0] an;
        logic [7:0] s;
        int d;
        while (digi[11:8] != 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (digi[11:8] != 4'b1110 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk({tag, "_align"}, 32'(n), 32'd0);
        for (int k = 0; k < 16; k++) begin
            d  = k / 4;
            an = ~(4'b0001 << d);
            s  = segs[8*d +: 8];
            pin(tag, 32'(digi), {20'b0, an, s});
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_size = SIZE_WORD; bus.mem_unsigned = 1'b0;
        check = 1'b0; showaddr = '0;

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        pin("rst_leds", 32'(leds), 32'h0);
        pin("rst_irq",  32'(interrupt), 32'h0);
        pin("rst_digi", 32'(digi), 32'h0000_0EFF);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        ld("rst_tcon", MMIO_BASE + 32'(OFF_TCON), SIZE_WORD, 1'b0, 32'h0);

        // Sub-word RAM access
        st(32'h10, 32'h1122_3344, SIZE_WORD);
        ld("lb_13",  32'h13, SIZE_BYTE, 1'b0, 32'h0000_0011);
        ld("lh_12",  32'h12, SIZE_HALF, 1'b0, 32'h0000_1122);
        st(32'h11, 32'h0000_00AA, SIZE_BYTE);
        ld("lw_10",  32'h10, SIZE_WORD, 1'b0, 32'h1122_AA44);
        ld("lhs_10", 32'h10, SIZE_HALF, 1'b0, 32'hFFFF_AA44);
        ld("lhu_10", 32'h10, SIZE_HALF, 1'b1, 32'h0000_AA44);
`ifdef MISALIGN_TRAP_EN
        ld("lh_odd", 32'h11, SIZE_HALF, 1'b0, 32'h0);
`else
        ld("lh_odd", 32'h11, SIZE_HALF, 1'b0, 32'hFFFF_AA44);
        ld("lw_13",  32'h13, SIZE_WORD, 1'b0, 32'h1122_AA44);
`endif
        st(32'h30, 32'h0000_0080, SIZE_BYTE);
        ld("lbu_80", 32'h30, SIZE_BYTE, 1'b1, 32'h0000_0080);
        ld("lbs_80", 32'h30, SIZE_BYTE, 1'b0, 32'hFFFF_FF80);

        @(negedge clk);
        bus.mem_addr = 32'h10; bus.mem_read = 1'b0; #1;
        pin("rd_idle", bus.mem_rdata, 32'h0);

        ld("ram_oob",  32'h0000_0400, SIZE_WORD, 1'b0, 32'h0);
        ld("unmapped", MMIO_BASE + 32'h18, SIZE_WORD, 1'b0, 32'h0);

        // LEDs, sub-word MMIO write ignored
        st(MMIO_BASE + 32'(OFF_LEDS), 32'h0000_00A5, SIZE_WORD);
        pin("leds_a5", 32'(leds), 32'h0000_00A5);
        st(MMIO_BASE + 32'(OFF_LEDS), 32'h0000_00FF, SIZE_BYTE);
        ld("leds_sb", MMIO_BASE + 32'(OFF_LEDS), SIZE_WORD, 1'b0, 32'h0000_00A5);

        // Systick advances one per cycle
        @(negedge clk);
        bus.mem_addr = MMIO_BASE + 32'(OFF_SYSTICK); bus.mem_size = SIZE_WORD;
        bus.mem_read = 1'b1; #1;
        t0 = bus.mem_rdata;
        bus.mem_read = 1'b0;
        repeat (3) @(negedge clk);
        ld("systick", MMIO_BASE + 32'(OFF_SYSTICK), SIZE_WORD, 1'b0, t0 + 32'd4);

        // Timer reload and interrupt
        st(MMIO_BASE + 32'(OFF_TH),   32'hFFFF_FFF0, SIZE_WORD);
        st(MMIO_BASE + 32'(OFF_TL),   32'hFFFF_FFFE, SIZE_WORD);
        st(MMIO_BASE + 32'(OFF_TCON), 32'h3, SIZE_WORD);
        ld("tl_ff", MMIO_BASE + 32'(OFF_TL), SIZE_WORD, 1'b0, 32'hFFFF_FFFF);
        pin("irq_pre", 32'(interrupt), 32'h0);
        ld("tl_rel", MMIO_BASE + 32'(OFF_TL), SIZE_WORD, 1'b0, 32'hFFFF_FFF0);
        pin("irq_set", 32'(interrupt), 32'h1);
        st(MMIO_BASE + 32'(OFF_TCON), 32'h3, SIZE_WORD);
        pin("irq_clr", 32'(interrupt), 32'h0);
        ld("tcon_3", MMIO_BASE + 32'(OFF_TCON), SIZE_WORD, 1'b0, 32'h3);
        st(MMIO_BASE + 32'(OFF_TCON), 32'h0, SIZE_WORD);

        // Overflow coincident with a TCON write: hardware set wins
        st(MMIO_BASE + 32'(OFF_TL),   32'hFFFF_FFFE, SIZE_WORD);
        st(MMIO_BASE + 32'(OFF_TCON), 32'h3, SIZE_WORD);
        st(MMIO_BASE + 32'(OFF_TCON), 32'h0, SIZE_WORD);
        ld("tcon_4", MMIO_BASE + 32'(OFF_TCON), SIZE_WORD, 1'b0, 32'h4);
        pin("irq_hold", 32'(interrupt), 32'h1);
        ld("tl_rel2", MMIO_BASE + 32'(OFF_TL), SIZE_WORD, 1'b0, 32'hFFFF_FFF0);

        // Async reset during a store: registers clear at once, RAM keeps its word
        @(negedge clk);
        bus.mem_addr = 32'h10; bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_size = SIZE_WORD;
        bus.mem_write = 1'b1;
        #2 reset = 1'b0;
        #1;
        pin("mrst_leds", 32'(leds), 32'h0);
        pin("mrst_irq",  32'(interrupt), 32'h0);
        pin("mrst_digi", 32'(digi), 32'h0000_0EFF);
        @(negedge clk);
        bus.mem_write = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        ld("mrst_ram",  32'h10, SIZE_WORD, 1'b0, 32'h1122_AA44);
        ld("mrst_th",   MMIO_BASE + 32'(OFF_TH),   SIZE_WORD, 1'b0, 32'h0);
        ld("mrst_tl",   MMIO_BASE + 32'(OFF_TL),   SIZE_WORD, 1'b0, 32'h0);
        ld("mrst_tcon", MMIO_BASE + 32'(OFF_TCON), SIZE_WORD, 1'b0, 32'h0);
        ld("mrst_led",  MMIO_BASE + 32'(OFF_LEDS), SIZE_WORD, 1'b0, 32'h0);

        // Display scan: hex of debug word, then raw DIGI bytes
        st(32'h20, 32'h0000_1234, SIZE_WORD);
        showaddr = 8'd8;
        check = 1'b1;
        #1;
        pin("showdata", ramshowdata, 32'h0000_1234);
        scan_run("scan_hex", 32'hF9A4_B099);
        st(MMIO_BASE + 32'(OFF_DIGI), 32'h1122_3344, SIZE_WORD);
        check = 1'b0;
        scan_run("scan_raw", 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
